ntt_core_seq: RTL

Sequencer and coefficient store for a 256-point forward NTT over q = 8380417, Dilithium Cooley-Tukey order. Loads 256 coefficients over a valid/ready stream and runs the 8 stages, one butterfly per cycle. Each butterfly drives X/Y into the combinational butterfly unit and the twiddle index into the zeta ROM, then writes the unit's A/B results back. It then streams the 256 results out. It sits directly upstream and downstream of the butterfly unit: it feeds X, Y and TF, and consumes A and B.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ntt_addr_gen.sv | 27 ++
 rtl/ntt_core_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the NTT datapath: sequencer, butterfly unit and zeta ROM.
package ntt_pkg;

    localparam int          DW   = 23;
    localparam int          LOGN = 8;
    localparam int          N    = 256;
    localparam logic [22:0] Q    = 23'd8380417;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        UNLOAD
    } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Maps (stage, butterfly) of the Cooley-Tukey schedule to the operand pair (j, j+len)
// and the zeta ROM index (1<<stage)+group.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0]      stage,
    input  logic [6:0]      bfly,
    output logic [LOGN-1:0] j_lo,
    output logic [LOGN-1:0] j_hi,
    output logic [7:0]      tf_idx
);

    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] ofs;

    // 2*len*g is g shifted by (8-s), since 2*len = 256>>s and g < 2^s
    always_comb begin
        len    = 8'd128 >> stage;
        grp    = {1'b0, bfly} >> (3'd7 - stage);
        ofs    = {1'b0, bfly} & (len - 8'd1);
        j_lo   = (grp << (4'd8 - {1'b0, stage})) | ofs;
        j_hi   = j_lo + len;
        tf_idx = (8'd1 << stage) + grp;
    end

endmodule

// File: rtl/ntt_core_seq.sv
// Sequencer and coefficient store for a 256-point forward NTT: load 256 words, run 8x128
// butterflies through the external butterfly unit, then stream the results out in natural order.
module ntt_core_seq
    import ntt_pkg::*;
#(
    parameter int DW   = 23,
    parameter int LOGN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          busy,
    output logic [7:0]    tf_idx,
    output logic [DW-1:0] bu_x,
    output logic [DW-1:0] bu_y,
    input  logic [DW-1:0] bu_a,
    input  logic [DW-1:0] bu_b
);

    localparam int NPTS = 1 << LOGN;

    state_t          state;
    state_t          state_nxt;
    logic [LOGN-1:0] ptr;
    logic [LOGN-1:0] ptr_nxt;
    logic [LOGN+1:0] cnt;
    logic [LOGN+1:0] cnt_nxt;
    logic [DW-1:0]   mem [NPTS];

    logic [LOGN-1:0] j_lo;
    logic [LOGN-1:0] j_hi;
    logic [7:0]      tf_raw;
    logic            in_hs;
    logic            out_hs;
    logic            ptr_end;
    logic            cnt_end;
    logic            run_act;

    // Run counter is {stage, butterfly}: upper 3 bits stage, lower 7 bits butterfly index
    ntt_addr_gen u_addr_gen (
        .stage  (cnt[LOGN+1:LOGN-1]),
        .bfly   (cnt[LOGN-2:0]),
        .j_lo   (j_lo),
        .j_hi   (j_hi),
        .tf_idx (tf_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        in_ready  = (state == IDLE) || (state == LOAD);
        out_valid = (state == UNLOAD);
        busy      = (state == RUN) || (state == UNLOAD);
        run_act   = (state == RUN);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        ptr_end   = &ptr;
        cnt_end   = &cnt;
        out_last  = out_valid && ptr_end;
        done      = out_hs && ptr_end;

        case (state)
            IDLE: begin
                if (in_hs) begin
                    ptr_nxt   = ptr + 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr_end) state_nxt = RUN;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt_end) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (out_hs) begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr_end) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tf_idx   = run_act ? tf_raw : 8'd0;
    assign bu_x     = run_act ? mem[j_lo] : '0;
    assign bu_y     = run_act ? mem[j_hi] : '0;
    assign out_data = mem[ptr];

    // Coefficient store is never reset; pairs within a stage are disjoint so both writes are safe
    always_ff @(posedge clk) begin
        if (in_hs) mem[ptr] <= in_data;
        if (run_act) begin
            mem[j_lo] <= bu_a;
            mem[j_hi] <= bu_b;
        end
    end

endmodule
